e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It sits directly downstream of the decode/execute pipeline register and consumes that register's rs/rt operand values and operation code. It performs multi-cycle MULT/MULTU/DIV/DIVU into architectural HI/LO registers and single-cycle MTHI/MTLO. It exports HI/LO for MFHI/MFLO, plus busy/stall status that the decode-stage hazard logic uses to hold mult/div-class instructions.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO commit (≥1)
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO commit (≥1)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  execute-stage instruction is MDU-class this cycle
- mdu_op  in  3  operation: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 is treated as NOP
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MT source)
- rt_val  in  32  forwarded rt operand (divisor / multiplier)
- busy  out  1  registered; 1 while a mult/div is in flight
- md_stall  out  1  combinational; busy | (start & op ∈ {MULT,MULTU,DIV,DIVU})
- hi  out  32  architectural HI, registered
- lo  out  32  architectural LO, registered

## Operation
- States: IDLE, BUSY. Down-counter `cnt` is 4 bits wide; 4 bits covers DIV_CYCLES up to 15.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - compute the 64-bit result from the current rs_val/rt_val into holding registers hi_t/lo_t
  - load cnt with MULT_CYCLES or DIV_CYCLES
  - go to BUSY
- IDLE, start=1, op MTHI/MTLO: write rs_val to hi/lo at that edge; stay IDLE; busy stays 0.
- IDLE, start=1, NOP or 7: no effect.
- BUSY: cnt decrements each edge. On the edge where cnt==1:
  - hi<=hi_t, lo<=lo_t
  - busy<=0
  - go to IDLE
- start while BUSY: ignored entirely, including MTHI/MTLO. Upstream stalls on md_stall, so this case is a fault condition, not a legal flow.
- Arithmetic:
  - MULT: signed 32x32→64; {hi,lo}=product
  - MULTU: unsigned 32x32→64; {hi,lo}=product
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder, which takes the sign of the dividend
  - DIVU: unsigned; lo=quotient; hi=remainder
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (rt_val==0, DIV or DIVU): the operation still occupies DIV_CYCLES; hi/lo keep their prior values at commit.
- Operands are sampled only at the accept edge. Later changes to rs_val/rt_val do not affect the result.

## Timing
- Reset (reset=0, asynchronous) drives all outputs and state to zero immediately:
  - busy=0, hi=0, lo=0, cnt=0, hi_t=0, lo_t=0, state IDLE
- Reset mid-operation discards the in-flight result.
- Accept at edge N: busy=1 from N through N+k-1, where k is MULT_CYCLES or DIV_CYCLES.
- At edge N+k: hi/lo update and busy falls at the same edge. A new start is accepted from edge N+k+1.
- md_stall rises in the same cycle as the accepting start, before busy is registered.
- MTHI/MTLO latency: 1 edge. A reader in the following cycle sees the new value.
- hi/lo are the only values MFHI/MFLO read. No bypass from hi_t/lo_t.

## Structure
- Package `mdu_pkg` holds:
  - mdu_op encodings (MDU_NOP..MDU_MTLO)
  - state encodings (IDLE/BUSY)
  - default cycle constants, used by the execute stage and the decode-stage hazard unit
- Sub-module `e_mdu_calc`: purely combinational 64-bit result generator (op, rs_val, rt_val → hi_r, lo_r, div0). `e_mdu` holds all the sequential logic.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (−2), rt=3 at edge 0:
  - busy=1 for cycles 1..5
  - edge 5: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU by 0 with prior hi=0x11, lo=0x22 → busy for 10 cycles; hi/lo unchanged.
- MTHI rs=0xDEADBEEF: hi=0xDEADBEEF next cycle, busy stays 0.
- MTLO issued while BUSY is ignored.
- DIV started, then reset asserted at cycle 4: busy, hi and lo are 0 immediately; after release, a fresh MULT 2×3 gives lo=6 at cycle 5.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the execute-stage multiply/divide unit.
// Also used by the decode-stage hazard unit to classify MDU instructions.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 4;

  // Multi-cycle ops that occupy the unit and stall decode.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit HI/LO result generator for MULT/MULTU/DIV/DIVU.
// Division runs on magnitudes so 0x80000000 / -1 needs no special case.
module e_mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi_r,
  output logic [31:0] lo_r,
  output logic        div0
);

  logic [63:0] prod_s, prod_u;
  logic        is_div, neg_a, neg_b;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  assign div0   = is_div && (rt_val == 32'd0);
  assign neg_a  = (op == MDU_DIV) && rs_val[31];
  assign neg_b  = (op == MDU_DIV) && rt_val[31];
  assign a_mag  = neg_a ? -rs_val : rs_val;
  // A zero divisor is replaced by 1 only to keep the divider defined; the result is discarded.
  assign b_mag  = (rt_val == 32'd0) ? 32'd1 : (neg_b ? -rt_val : rt_val);
  assign q_mag  = a_mag / b_mag;
  assign r_mag  = a_mag % b_mag;
  assign quot   = (neg_a ^ neg_b) ? -q_mag : q_mag;
  assign rem    = neg_a ? -r_mag : r_mag;

  always_comb begin
    hi_r = '0;
    lo_r = '0;
    case (op)
      MDU_MULT:           {hi_r, lo_r} = prod_s;
      MDU_MULTU:          {hi_r, lo_r} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        hi_r = rem;
        lo_r = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage MDU: latches the product/quotient at accept, counts down the
// architectural latency, then commits into HI/LO. MTHI/MTLO write in one edge.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          hi_t_q, hi_t_d, lo_t_q, lo_t_d;
  logic [31:0]          hi_q, hi_d, lo_q, lo_d;
  logic                 div0_q, div0_d;
  logic                 busy_q, busy_d;

  logic [31:0] hi_r, lo_r;
  logic        div0;

  e_mdu_calc u_calc (
    .op     (mdu_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_r   (hi_r),
    .lo_r   (lo_r),
    .div0   (div0)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_t_d  = hi_t_q;
    lo_t_d  = lo_t_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_md_op(mdu_op)) begin
            hi_t_d  = hi_r;
            lo_t_d  = lo_r;
            div0_d  = div0;
            cnt_d   = ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU)) ? MULT_CNT : DIV_CNT;
            busy_d  = 1'b1;
            state_d = BUSY;
          end else if (mdu_op == MDU_MTHI) begin
            hi_d = rs_val;
          end else if (mdu_op == MDU_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      BUSY: begin
        // Any start here is a hazard-unit fault and is dropped.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == MDU_CNT_W'(1)) begin
          if (!div0_q) begin
            hi_d = hi_t_q;
            lo_d = lo_t_q;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_t_q  <= '0;
      lo_t_q  <= '0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_t_q  <= hi_t_d;
      lo_t_q  <= lo_t_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign md_stall = busy_q | (start & is_md_op(mdu_op));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: arithmetic corner cases, latency, MT ops, busy-drop and async reset.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one op for exactly one rising edge, then scramble operands to prove sampling.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 3'd0; rs_val = 32'h5A5A_1234; rt_val = 32'h0F0F_0003;
  endtask

  // After an accept edge: busy must hold k-1 more edges with HI/LO frozen, then commit.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int k, input logic [31:0] ehi,
                        input logic [31:0] elo);
    logic [31:0] ph, pl;
    ph = hi; pl = lo;
    issue(op, a, b);
    chk({tag, ".busy_acc"}, {31'b0, busy}, 32'd1);
    for (int i = 1; i < k; i++) begin
      @(posedge clk); #1;
      chk({tag, ".busy_mid"}, {31'b0, busy}, 32'd1);
      if (i == k - 1) chk({tag, ".hi_hold"}, hi, ph);
    end
    chk({tag, ".lo_hold"}, lo, pl);
    @(posedge clk); #1;
    chk({tag, ".busy_end"}, {31'b0, busy}, 32'd0);
    chk({tag, ".hi"}, hi, ehi);
    chk({tag, ".lo"}, lo, elo);
  endtask

  initial begin
    #2;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // md_stall is combinational on the accepting start
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
    #1 chk("stall.comb", {31'b0, md_stall}, 32'd1);
    chk("stall.busy0", {31'b0, busy}, 32'd0);
    start = 1'b0; mdu_op = MDU_NOP;

    run_op("mult",  MDU_MULT,  32'hFFFF_FFFE, 32'd3,         5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divov", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

    issue(MDU_MTHI, 32'h11, 32'd0);
    chk("mthi11.hi", hi, 32'h11);
    issue(MDU_MTLO, 32'h22, 32'd0);
    chk("mtlo22.lo", lo, 32'h22);
    chk("mtlo22.busy", {31'b0, busy}, 32'd0);
    run_op("divu0", MDU_DIVU, 32'd1234, 32'd0, 10, 32'h11, 32'h22);

    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MTHI; rs_val = 32'hDEAD_BEEF;
    #1 chk("mthi.nostall", {31'b0, md_stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NOP;
    chk("mthi.hi", hi, 32'hDEAD_BEEF);
    chk("mthi.busy", {31'b0, busy}, 32'd0);

    // MTLO while busy must be dropped; result commits normally
    issue(MDU_DIVU, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MTLO; rs_val = 32'h55;
    #1 chk("busy.stall", {31'b0, md_stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NOP;
    chk("busy.mtlo_ign", lo, 32'h22);
    repeat (6) @(posedge clk);
    #1 chk("divu.busy9", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("divu.busy_end", {31'b0, busy}, 32'd0);
    chk("divu.lo", lo, 32'd14);
    chk("divu.hi", hi, 32'd2);

    // Async reset mid-divide
    issue(MDU_DIV, 32'd50, 32'd5);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst.busy", {31'b0, busy}, 32'd0);
    chk("arst.hi", hi, 32'd0);
    chk("arst.lo", lo, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("arst.nocommit", lo, 32'd0);
    run_op("mult23", MDU_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
